// File: rtl/processor_mc.sv
// rtl/processor_mc.sv - multi-cycle RV32I/RV64I integer-ALU subset core
// Each instruction steps through FETCH, DECODE, EXECUTE and WRITEBACK, one cycle each.
module processor_mc #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic [$clog2(NREGS)-1:0]      dbg_addr,
  output logic [XLEN-1:0]               dbg_data,
  output logic [XLEN-1:0]               pc,
  output logic                          zero,
  output logic                          halted,
  output logic                          illegal,
  output logic [31:0]                   retired
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t state, state_next;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_out, pc_q;
  logic            zero_q, illegal_q;
  logic [31:0]     retired_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            is_r, is_i, legal, shift_hi_ok;
  logic [11:0]     shift_mask;
  logic [XLEN-1:0] op_b, result;
  logic [SW-1:0]   shamt;
  logic [IW-1:0]   next_word;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[15 +: RW];
  assign rs2    = ir[20 +: RW];
  assign rd     = ir[7 +: RW];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);

  // Immediate shifts: everything above the shamt field must be zero, except bit 30 (SRAI).
  assign shift_mask  = ~12'(XLEN - 1) & ~12'h400;
  assign shift_hi_ok = ((ir[31:20] & shift_mask) == 12'h000);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_i) begin
      case (funct3)
        3'b001:  legal = shift_hi_ok && !ir[30];
        3'b101:  legal = shift_hi_ok;
        default: legal = 1'b1;
      endcase
    end
  end

  assign op_b  = is_r ? b_q : imm_q;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    result = '0;
    case (funct3)
      3'b000: result = (is_r && ir[30]) ? a_q - op_b : a_q + op_b;
      3'b001: result = a_q << shamt;
      3'b010: result = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
      3'b011: result = {{(XLEN-1){1'b0}}, (a_q < op_b)};
      3'b100: result = a_q ^ op_b;
      3'b101: result = ir[30] ? XLEN'($signed(a_q) >>> shamt) : a_q >> shamt;
      3'b110: result = a_q | op_b;
      3'b111: result = a_q & op_b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_FETCH;
      S_FETCH:     state_next = S_DECODE;
      S_DECODE:    state_next = legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_IDLE;
    endcase
  end

  // Instruction memory survives reset so a program can be rerun after an abort.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && load_en) imem[load_addr] <= load_data;
  end

  assign next_word = pc_q[IW+1:2] + IW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out   <= '0;
      pc_q      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: ir <= imem[pc_q[IW+1:2]];
        S_DECODE: begin
          a_q   <= regs[rs1];
          b_q   <= regs[rs2];
          imm_q <= {{(XLEN-12){ir[31]}}, ir[31:20]};
          if (!legal && ir != ECALL) illegal_q <= 1'b1;
        end
        S_EXECUTE: begin
          alu_out <= result;
          zero_q  <= (result == '0);
        end
        S_WRITEBACK: begin
          if (rd != '0) regs[rd] <= alu_out;
          pc_q      <= {{(XLEN-IW-2){1'b0}}, next_word, 2'b00};
          retired_q <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  assign pc       = pc_q;
  assign zero     = zero_q;
  assign halted   = (state == S_HALT);
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: doc/processor_mc.md
PROCESSOR_MC -- requirements
Module: processor_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath/register width; legal values 32 or 64.
REQ-002 Parameter NREGS, default 32, architectural register count; legal values 16 or 32.
REQ-003 Parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words; power of two.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 start  in  1  in IDLE, starts execution at pc=0; ignored in other states.
REQ-007 load_en, load_addr, load_data  in  1 / log2(IMEM_DEPTH) / 32  instruction-memory write port.
REQ-008 dbg_addr  in  log2(NREGS)  register index for debug read.
REQ-009 dbg_data  out  XLEN  combinational read of register dbg_addr; index 0 reads 0.
REQ-010 pc  out  XLEN  current byte program counter.
REQ-011 zero  out  1  registered; 1 when the last EXECUTE result was 0.
REQ-012 halted  out  1  high in HALT state.
REQ-013 illegal  out  1  sticky; high when halt was caused by an unsupported instruction.
REQ-014 retired  out  32  count of completed (written-back) instructions.

Function
REQ-015 FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; one state per cycle.
REQ-016 IDLE->FETCH on start=1; FETCH->DECODE; DECODE->EXECUTE for supported ops, ->HALT otherwise; EXECUTE->WRITEBACK; WRITEBACK->FETCH; HALT holds until reset.
REQ-017 FETCH: IR <= imem[pc[log2(IMEM_DEPTH)+1:2]].
REQ-018 DECODE: latch A<=reg[rs1], B<=reg[rs2], sign-extended 12-bit I-immediate; rs/rd bits above log2(NREGS) ignored.
REQ-019 Supported, opcode 0110011 (R): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, selected by funct3/funct7[5]; any other funct7 is illegal.
REQ-020 Supported, opcode 0010011 (I): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
REQ-021 Shift amount = low log2(XLEN) bits of B or immediate; SRA/SRAI arithmetic; add/sub wrap modulo 2^XLEN; SLT signed, SLTU unsigned, result 0 or 1.
REQ-022 EXECUTE: ALUOut <= result; zero <= (result==0).
REQ-023 WRITEBACK: reg[rd] <= ALUOut unless rd==0 (x0 always 0); pc <= pc+4; retired <= retired+1.
REQ-024 pc wraps to 0 after byte address 4*IMEM_DEPTH-4.
REQ-025 Instruction 0x00000073 (ECALL) in DECODE -> HALT, illegal=0; any other unsupported word -> HALT, illegal=1; neither retires nor changes pc.
REQ-026 Latency: 4 cycles per retired instruction; first FETCH in the cycle after start sampled high.
REQ-027 Load port writes imem[load_addr] <= load_data only in IDLE; ignored in all other states.
REQ-028 retired wraps modulo 2^32.

Reset
REQ-029 reset=0: state=IDLE, pc=0, all registers=0, zero=0, halted=0, illegal=0, retired=0; imem contents not cleared.
REQ-030 reset asserted mid-instruction aborts it: no writeback, no retire, outputs at REQ-029 values before the next edge.

Verification
REQ-031 Load 0x00500093, 0xFFD00113, 0x002081B3, 0x40108233, 0x00000073; start -> halted=1, illegal=0, x1=5, x2=-3 (0xFFFFFFFD), x3=2, x4=0, zero=1, retired=4, pc=0x10; halted rises 18 cycles after start edge.
REQ-032 Load 0x00700013 (ADDI x0,x0,7), then ECALL -> dbg x0=0, retired=1.
REQ-033 Load 0xFFFFFFFF at word 0 -> halted=1, illegal=1, retired=0, pc=0.
REQ-034 IMEM_DEPTH=4, words 0-3 ADDI x1,x1,1 (0x00108093) -> after 5 retires pc=4 (wrapped), x1=5.
REQ-035 Assert reset during EXECUTE of first ADDI -> x1=0, retired=0, state IDLE; load_en pulse while running does not alter imem.
